vga_grid_display: RTL and testbench

Generates 640x480@60 VGA timing from the pixel clock and renders a 10-column x 20-row playfield of 3-bit colour cells as a centred, bordered board. Each frame it snapshots the playfield input during vertical blanking, so game logic may update its grid at any time without tearing. It sits between the game-state logic and the board's VGA pins and supplies the raster counters used by overlay logic.

---
 rtl/vga_grid_display.sv | 215 +++++++++++++++++++++
 tb/tb_vga_grid_display.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_grid_display.sv
// 640x480@60 VGA raster generator that draws a bordered 10x20 playfield, snapshotted once per frame.
// Optional build macro GRID_LINES_EN darkens the last pixel row/column of each cell to draw a grid.
module vga_grid_display (
    input  logic         clock,
    input  logic         reset,
    input  logic [599:0] frame,
    output logic [2:0]   vga_pixel,
    output logic         hsync_out,
    output logic         vsync_out,
    output logic         in_display,
    output logic [9:0]   count_x,
    output logic [9:0]   count_y,
    output logic [10:0]  frame_count
);

    localparam logic [9:0] H_LAST      = 10'd799;
    localparam logic [9:0] V_LAST      = 10'd524;
    localparam logic [9:0] H_VISIBLE   = 10'd640;
    localparam logic [9:0] V_VISIBLE   = 10'd480;
    localparam logic [9:0] HS_START    = 10'd656;
    localparam logic [9:0] HS_END      = 10'd751;
    localparam logic [9:0] VS_START    = 10'd490;
    localparam logic [9:0] VS_END      = 10'd491;
    localparam logic [9:0] BOARD_X0    = 10'd220;
    localparam logic [9:0] BOARD_X1    = 10'd420;
    localparam logic [9:0] BOARD_Y0    = 10'd40;
    localparam logic [9:0] BOARD_Y1    = 10'd440;
    localparam logic [9:0] BORDER_X0   = 10'd218;
    localparam logic [9:0] BORDER_X1   = 10'd422;
    localparam logic [9:0] BORDER_Y0   = 10'd38;
    localparam logic [9:0] BORDER_Y1   = 10'd442;
    localparam logic [4:0] CELL_LAST   = 5'd19;
    localparam logic [2:0] COLOUR_OFF  = 3'b000;
    localparam logic [2:0] COLOUR_EDGE = 3'b111;

    logic [9:0]   x_r;
    logic [9:0]   y_r;
    logic [599:0] snap_r;
    logic [10:0]  fc_r;
    logic [4:0]   x_off_r;
    logic [3:0]   x_cell_r;
    logic [4:0]   y_off_r;
    logic [4:0]   y_cell_r;

    logic [9:0]   x_nxt_s;
    logic [9:0]   y_nxt_s;
    logic [4:0]   x_off_nxt_s;
    logic [3:0]   x_cell_nxt_s;
    logic [4:0]   y_off_nxt_s;
    logic [4:0]   y_cell_nxt_s;
    logic         line_end_s;
    logic         snap_take_s;
    logic         visible_s;
    logic         x_board_s;
    logic         y_board_s;
    logic         board_s;
    logic         border_s;
    logic         grid_line_s;
    logic [29:0]  row_bits_s;
    logic [2:0]   cell_colour_s;
    logic [2:0]   pixel_s;

    // Raster position advance with line and frame wrap.
    always_comb begin
        line_end_s = (x_r == H_LAST);
        if (line_end_s) begin
            x_nxt_s = 10'd0;
            if (y_r == V_LAST) begin
                y_nxt_s = 10'd0;
            end else begin
                y_nxt_s = y_r + 10'd1;
            end
        end else begin
            x_nxt_s = x_r + 10'd1;
            y_nxt_s = y_r;
        end
    end

    // Region decodes of the current position.
    always_comb begin
        visible_s   = (x_r < H_VISIBLE) && (y_r < V_VISIBLE);
        x_board_s   = (x_r >= BOARD_X0) && (x_r < BOARD_X1);
        y_board_s   = (y_r >= BOARD_Y0) && (y_r < BOARD_Y1);
        board_s     = x_board_s && y_board_s;
        border_s    = (x_r >= BORDER_X0) && (x_r < BORDER_X1) &&
                      (y_r >= BORDER_Y0) && (y_r < BORDER_Y1);
        snap_take_s = (x_r == 10'd0) && (y_r == VS_START);
    end

    // Horizontal cell/offset sub-counters: they are re-armed one pixel before the board starts,
    // so they are valid whenever x_r lies inside the board.
    always_comb begin
        x_off_nxt_s  = x_off_r;
        x_cell_nxt_s = x_cell_r;
        if (x_nxt_s == BOARD_X0) begin
            x_off_nxt_s  = 5'd0;
            x_cell_nxt_s = 4'd0;
        end else if (x_board_s) begin
            if (x_off_r == CELL_LAST) begin
                x_off_nxt_s  = 5'd0;
                x_cell_nxt_s = x_cell_r + 4'd1;
            end else begin
                x_off_nxt_s  = x_off_r + 5'd1;
                x_cell_nxt_s = x_cell_r;
            end
        end else begin
            x_off_nxt_s  = x_off_r;
            x_cell_nxt_s = x_cell_r;
        end
    end

    // Vertical cell/offset sub-counters, stepped once per line.
    always_comb begin
        y_off_nxt_s  = y_off_r;
        y_cell_nxt_s = y_cell_r;
        if (!line_end_s) begin
            y_off_nxt_s  = y_off_r;
            y_cell_nxt_s = y_cell_r;
        end else if (y_nxt_s == BOARD_Y0) begin
            y_off_nxt_s  = 5'd0;
            y_cell_nxt_s = 5'd0;
        end else if (y_board_s) begin
            if (y_off_r == CELL_LAST) begin
                y_off_nxt_s  = 5'd0;
                y_cell_nxt_s = y_cell_r + 5'd1;
            end else begin
                y_off_nxt_s  = y_off_r + 5'd1;
                y_cell_nxt_s = y_cell_r;
            end
        end else begin
            y_off_nxt_s  = y_off_r;
            y_cell_nxt_s = y_cell_r;
        end
    end

    // Cell colour lookup as a row mux followed by a column mux.
    always_comb begin
        row_bits_s    = 30'd0;
        cell_colour_s = COLOUR_OFF;
        for (int r = 0; r < 20; r++) begin
            if (y_cell_r == 5'(r)) begin
                row_bits_s = snap_r[r*30 +: 30];
            end else begin
                row_bits_s = row_bits_s;
            end
        end
        for (int c = 0; c < 10; c++) begin
            if (x_cell_r == 4'(c)) begin
                cell_colour_s = row_bits_s[c*3 +: 3];
            end else begin
                cell_colour_s = cell_colour_s;
            end
        end
    end

`ifdef GRID_LINES_EN
    assign grid_line_s = (x_off_r == CELL_LAST) || (y_off_r == CELL_LAST);
`else
    assign grid_line_s = 1'b0;
`endif

    // Pixel colour by priority: blanking, board, border, background.
    always_comb begin
        if (!visible_s) begin
            pixel_s = COLOUR_OFF;
        end else if (board_s) begin
            if (grid_line_s) begin
                pixel_s = COLOUR_OFF;
            end else begin
                pixel_s = cell_colour_s;
            end
        end else if (border_s) begin
            pixel_s = COLOUR_EDGE;
        end else begin
            pixel_s = COLOUR_OFF;
        end
    end

    // Raster, sub-counter and snapshot state.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_r      <= 10'd0;
            y_r      <= 10'd0;
            x_off_r  <= 5'd0;
            x_cell_r <= 4'd0;
            y_off_r  <= 5'd0;
            y_cell_r <= 5'd0;
            snap_r   <= 600'd0;
            fc_r     <= 11'd0;
        end else begin
            x_r      <= x_nxt_s;
            y_r      <= y_nxt_s;
            x_off_r  <= x_off_nxt_s;
            x_cell_r <= x_cell_nxt_s;
            y_off_r  <= y_off_nxt_s;
            y_cell_r <= y_cell_nxt_s;
            if (snap_take_s) begin
                snap_r <= frame;
                fc_r   <= fc_r + 11'd1;
            end else begin
                snap_r <= snap_r;
                fc_r   <= fc_r;
            end
        end
    end

    assign count_x     = x_r;
    assign count_y     = y_r;
    assign frame_count = fc_r;
    assign in_display  = visible_s;
    assign hsync_out   = !((x_r >= HS_START) && (x_r <= HS_END));
    assign vsync_out   = !((y_r >= VS_START) && (y_r <= VS_END));
    assign vga_pixel   = pixel_s;

endmodule

// File: tb/tb_vga_grid_display.sv
// Scoreboard bench: a position/snapshot reference model pushes expected outputs per edge,
// a monitor pops and compares them on the falling edge.
module tb_vga_grid_display;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  pix;
        logic        hs;
        logic        vs;
        logic        disp;
        logic [10:0] fc;
    } obs_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [599:0] frame_in = 600'd0;
    logic [2:0]   vga_pixel;
    logic         hsync_out;
    logic         vsync_out;
    logic         in_display;
    logic [9:0]   count_x;
    logic [9:0]   count_y;
    logic [10:0]  frame_count;

    int checks = 0;
    int failures = 0;
    obs_t exp_q[$];

    int           m_t = 0;
    int           m_fc = 0;
    logic [599:0] m_snap = 600'd0;
    logic [599:0] pat_a;
    logic [599:0] pat_b;

    vga_grid_display dut (
        .clock       (clock),
        .reset       (reset),
        .frame       (frame_in),
        .vga_pixel   (vga_pixel),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .in_display  (in_display),
        .count_x     (count_x),
        .count_y     (count_y),
        .frame_count (frame_count)
    );

    always #20 clock = ~clock;

    function automatic logic [2:0] ref_pixel(input int x, input int y, input logic [599:0] s);
        int c;
        int r;
        if (!(x < 640 && y < 480)) return 3'b000;
        if (x >= 220 && x < 420 && y >= 40 && y < 440) begin
            c = (x - 220) / 20;
            r = (y - 40) / 20;
`ifdef GRID_LINES_EN
            if ((x - 220) % 20 == 19 || (y - 40) % 20 == 19) return 3'b000;
`endif
            return s[(r*10 + c)*3 +: 3];
        end
        if (x >= 218 && x < 422 && y >= 38 && y < 442) return 3'b111;
        return 3'b000;
    endfunction

    task automatic step(input logic rst);
        int px;
        int py;
        obs_t e;
        reset = rst;
        @(posedge clock);
        #1;
        if (rst) begin
            m_t = 0;
            m_fc = 0;
            m_snap = 600'd0;
        end else begin
            px = m_t % 800;
            py = m_t / 800;
            if (px == 0 && py == 490) begin
                m_snap = frame_in;
                m_fc = (m_fc + 1) % 2048;
            end
            m_t = (m_t + 1) % 420000;
        end
        px = m_t % 800;
        py = m_t / 800;
        e.x = 10'(px);
        e.y = 10'(py);
        e.pix = ref_pixel(px, py, m_snap);
        e.hs = !(px >= 656 && px < 752);
        e.vs = !(py == 490 || py == 491);
        e.disp = (px < 640) && (py < 480);
        e.fc = 11'(m_fc);
        exp_q.push_back(e);
    endtask

    // Monitor: compares every observed cycle and tallies sync pulse widths.
    initial begin
        obs_t e;
        obs_t a;
        int hs_low = 0;
        int vs_low = 0;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{count_x, count_y, vga_pixel, hsync_out, vsync_out, in_display, frame_count};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL cycle at exp (%0d,%0d): actual x=%0d y=%0d pix=%b hs=%b vs=%b disp=%b fc=%0d required pix=%b hs=%b vs=%b disp=%b fc=%0d",
                             e.x, e.y, a.x, a.y, a.pix, a.hs, a.vs, a.disp, a.fc,
                             e.pix, e.hs, e.vs, e.disp, e.fc);
                end
                if (e.x == 10'd0) hs_low = 0;
                if (e.x == 10'd0 && e.y == 10'd0) vs_low = 0;
                if (!hsync_out) hs_low++;
                if (!vsync_out) vs_low++;
                if (e.x == 10'd799) begin
                    checks++;
                    if (hs_low != 96) begin
                        failures++;
                        $display("FAIL hsync_width line %0d: actual %0d required 96", e.y, hs_low);
                    end
                end
                if (e.x == 10'd799 && e.y == 10'd524) begin
                    checks++;
                    if (vs_low != 1600) begin
                        failures++;
                        $display("FAIL vsync_width: actual %0d required 1600", vs_low);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #(40 * 700000);
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int drain;
        for (int i = 0; i < 600; i++) frame_in[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 600; i++) pat_a[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 600; i++) pat_b[i] = 1'($urandom_range(0, 1));
        pat_a[2:0] = 3'b001;
        pat_a[599:597] = 3'b100;

        step(1'b1);
        step(1'b1);
        // Frame 0: pattern A applied mid-frame, sampled at line 490, replaced by B just after.
        for (int k = 1; k <= 500300; k++) begin
            if (k == 200 * 800) frame_in = pat_a;
            if (k == 495 * 800) frame_in = pat_b;
            step(1'b0);
        end
        // Reset at (300,100) of frame 1, then observe a blank board.
        step(1'b1);
        for (int k = 0; k < 60 * 800; k++) step(1'b0);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clock);
            drain++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: actual %0d entries left required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
